// File: rtl/lcm_pkg.sv
// -----------------------------------------------------------------------------
// lcm_pkg
// Shared constants and types for the LCM client slice.
//   - default operand width and engine timeout
//   - timer width helper
//   - FSM state encodings (3-bit constants)
//   - debug bundle exposed by lcm_client
// -----------------------------------------------------------------------------
package lcm_pkg;

  localparam int WIDTH_DEFAULT          = 8;
  localparam int TIMEOUT_CYCLES_DEFAULT = 1024;

  // The timer counts 0 .. cycles-1, so $clog2(cycles) bits are enough.
  // A one-cycle timeout still needs a 1-bit register.
  function automatic int timer_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

  localparam int TIMER_W_DEFAULT = timer_width(TIMEOUT_CYCLES_DEFAULT);

  typedef logic [2:0] lcm_state_t;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_ISSUE    = 3'd1;
  localparam logic [2:0] ST_WAIT_GCD = 3'd2;
  localparam logic [2:0] ST_DIVIDE   = 3'd3;
  localparam logic [2:0] ST_RESP     = 3'd4;

  // Observation bundle: FSM state plus divider status.
  typedef struct packed {
    lcm_state_t state;
    logic       div_busy;
    logic       div_rem_nz;
  } lcm_dbg_t;

endpackage

// File: rtl/lcm_client_seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
// Iterative restoring divider: NW-bit dividend / DW-bit divisor, one quotient
// bit per clock, NW iteration cycles after the start cycle.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   start        load dividend/divisor (ignored while busy)
//   dividend     NW-bit numerator
//   divisor      DW-bit denominator (caller guarantees nonzero)
//   busy         iterations in progress
//   done         one-cycle pulse after the last iteration; results valid
//   quotient     NW-bit quotient (held until next start)
//   remainder    DW-bit remainder (held until next start)
// -----------------------------------------------------------------------------
module seq_divider #(
  parameter int DW = 8,
  parameter int NW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [NW-1:0] dividend,
  input  logic [DW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [NW-1:0] quotient,
  output logic [DW-1:0] remainder
);

  localparam int            CW   = $clog2(NW) + 1;
  localparam logic [CW-1:0] LAST = CW'(NW - 1);

  logic [NW-1:0] r_quo;
  logic [DW-1:0] r_rem;
  logic [DW-1:0] r_div;
  logic [CW-1:0] r_cnt;
  logic          r_busy;
  logic          r_done;

  // The quotient register doubles as the dividend shift register: its MSB
  // is shifted into the partial remainder and the new quotient bit enters
  // at the LSB.
  logic [DW:0]   w_shift;
  logic          w_fits;
  logic [DW-1:0] w_diff;

  assign w_shift = {r_rem, r_quo[NW-1]};
  assign w_fits  = (w_shift >= {1'b0, r_div});
  // When the divisor fits, the true difference is below 2^DW, so the
  // modular DW-bit subtraction is exact.
  assign w_diff  = w_shift[DW-1:0] - r_div;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_quo  <= '0;
      r_rem  <= '0;
      r_div  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (start && !r_busy) begin
        r_quo  <= dividend;
        r_rem  <= '0;
        r_div  <= divisor;
        r_cnt  <= '0;
        r_busy <= 1'b1;
      end else if (r_busy) begin
        r_rem <= w_fits ? w_diff : w_shift[DW-1:0];
        r_quo <= {r_quo[NW-2:0], w_fits};
        r_cnt <= r_cnt + CW'(1);
        if (r_cnt == LAST) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign quotient  = r_quo;
  assign remainder = r_rem;

endmodule

// File: rtl/lcm_client.sv
// -----------------------------------------------------------------------------
// lcm_client
// Initiator for an external start/done GCD engine. Takes an operand pair,
// obtains the GCD from the engine, then computes LCM = a*b/gcd with a
// sequential divider and returns both results.
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   req_valid/req_ready    request handshake, operands req_a/req_b
//   gcd_start              one-cycle start pulse to the engine
//   gcd_a/gcd_b            latched operands presented to the engine
//   gcd_result/gcd_done    engine result and completion flag
//   rsp_valid/rsp_ready    response handshake
//   lcm_out, gcd_q         results (2*WIDTH and WIDTH bits)
//   timeout_err            engine failed to complete in TIMEOUT_CYCLES
//   dbg                    FSM state and divider status for observation
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. req_ready is high only in IDLE (and not in the first cycle out
// of reset); rsp_valid is high only in RESP and its payload is held stable
// until the transfer. Neither ready depends combinationally on its valid.
// -----------------------------------------------------------------------------
module lcm_client
  import lcm_pkg::*;
#(
  parameter int WIDTH          = WIDTH_DEFAULT,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [WIDTH-1:0]   req_a,
  input  logic [WIDTH-1:0]   req_b,
  output logic               gcd_start,
  output logic [WIDTH-1:0]   gcd_a,
  output logic [WIDTH-1:0]   gcd_b,
  input  logic [WIDTH-1:0]   gcd_result,
  input  logic               gcd_done,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [2*WIDTH-1:0] lcm_out,
  output logic [WIDTH-1:0]   gcd_q,
  output logic               timeout_err,
  output lcm_dbg_t           dbg
);

  localparam int            TW       = timer_width(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT_CYCLES - 1);

  lcm_state_t         r_state;
  logic               r_req_ready;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_g;
  logic [TW-1:0]      r_tmr;
  logic [2*WIDTH-1:0] r_lcm;
  logic [WIDTH-1:0]   r_gcd;
  logic               r_terr;

  logic               w_accept;
  logic               w_zero_op;
  logic               w_div_start;
  logic [2*WIDTH-1:0] w_prod;
  logic               w_div_busy;
  logic               w_div_done;
  logic [2*WIDTH-1:0] w_div_quo;
  logic [WIDTH-1:0]   w_div_rem;

  // r_req_ready only rises while in IDLE, so it alone qualifies acceptance.
  assign w_accept  = req_valid && r_req_ready;
  // The engine never terminates on a zero operand, so those bypass it.
  assign w_zero_op = (req_a == '0) || (req_b == '0);

  // The divider is launched on the same edge that captures the GCD, fed
  // straight from the engine and the latched operands. This keeps the
  // DIVIDE phase at 2*WIDTH iterations plus the result register cycle.
  assign w_div_start = (r_state == ST_WAIT_GCD) && gcd_done;
  assign w_prod      = {{WIDTH{1'b0}}, r_a} * {{WIDTH{1'b0}}, r_b};

  seq_divider #(
    .DW (WIDTH),
    .NW (2*WIDTH)
  ) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (w_div_start),
    .dividend  (w_prod),
    .divisor   (gcd_result),
    .busy      (w_div_busy),
    .done      (w_div_done),
    .quotient  (w_div_quo),
    .remainder (w_div_rem)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_req_ready <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_g         <= '0;
      r_tmr       <= '0;
      r_lcm       <= '0;
      r_gcd       <= '0;
      r_terr      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_a         <= req_a;
            r_b         <= req_b;
            r_terr      <= 1'b0;
            r_req_ready <= 1'b0;
            if (w_zero_op) begin
              r_lcm   <= '0;
              r_gcd   <= req_a | req_b;
              r_state <= ST_RESP;
            end else begin
              r_state <= ST_ISSUE;
            end
          end else begin
            r_req_ready <= 1'b1;
          end
        end
        ST_ISSUE: begin
          // A done still high from the previous run is ignored here; the
          // engine drops it on the edge that samples gcd_start.
          r_tmr   <= '0;
          r_state <= ST_WAIT_GCD;
        end
        ST_WAIT_GCD: begin
          if (gcd_done) begin
            r_g     <= gcd_result;
            r_state <= ST_DIVIDE;
          end else if (r_tmr == TMR_LAST) begin
            r_terr  <= 1'b1;
            r_lcm   <= '0;
            r_gcd   <= '0;
            r_state <= ST_RESP;
          end else begin
            r_tmr <= r_tmr + TW'(1);
          end
        end
        ST_DIVIDE: begin
          if (w_div_done) begin
            r_lcm   <= w_div_quo;
            r_gcd   <= r_g;
            r_state <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_req_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_req_ready <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready   = r_req_ready;
  assign gcd_start   = (r_state == ST_ISSUE);
  assign gcd_a       = r_a;
  assign gcd_b       = r_b;
  assign rsp_valid   = (r_state == ST_RESP);
  assign lcm_out     = r_lcm;
  assign gcd_q       = r_gcd;
  assign timeout_err = r_terr;

  assign dbg = '{state: r_state, div_busy: w_div_busy, div_rem_nz: |w_div_rem};

endmodule

// File: tb/tb_lcm_client.sv
// -----------------------------------------------------------------------------
// tb_lcm_client
// Self-checking bench for lcm_client with a behavioural subtractive GCD
// engine attached. Expected results come from a Euclid-based reference
// model; timing expectations come from the documented latencies.
// -----------------------------------------------------------------------------
module tb_lcm_client;
  import lcm_pkg::*;

  localparam int W  = 8;
  localparam int TO = 1024;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic           req_valid = 1'b0;
  logic           req_ready;
  logic [W-1:0]   req_a = '0;
  logic [W-1:0]   req_b = '0;
  logic           gcd_start;
  logic [W-1:0]   gcd_a;
  logic [W-1:0]   gcd_b;
  logic [W-1:0]   gcd_result;
  logic           gcd_done;
  logic           rsp_valid;
  logic           rsp_ready = 1'b0;
  logic [2*W-1:0] lcm_out;
  logic [W-1:0]   gcd_q;
  logic           timeout_err;
  lcm_dbg_t       dbg;

  lcm_client #(.WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .gcd_start   (gcd_start),
    .gcd_a       (gcd_a),
    .gcd_b       (gcd_b),
    .gcd_result  (gcd_result),
    .gcd_done    (gcd_done),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .lcm_out     (lcm_out),
    .gcd_q       (gcd_q),
    .timeout_err (timeout_err),
    .dbg         (dbg)
  );

  // ---------------- behavioural GCD engine ----------------
  // Subtractive engine; done stays high until the next start. eng_stub
  // freezes it so it never completes.
  logic [W-1:0] eng_x, eng_y;
  logic         eng_busy;
  bit           eng_stub = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      eng_x <= '0; eng_y <= '0; eng_busy <= 1'b0;
      gcd_done <= 1'b0; gcd_result <= '0;
    end else if (gcd_start) begin
      eng_x <= gcd_a; eng_y <= gcd_b; eng_busy <= 1'b1; gcd_done <= 1'b0;
    end else if (eng_busy && !eng_stub) begin
      if (eng_x == eng_y) begin
        gcd_result <= eng_x; gcd_done <= 1'b1; eng_busy <= 1'b0;
      end else if (eng_x > eng_y) eng_x <= eng_x - eng_y;
      else eng_y <= eng_y - eng_x;
    end
  end

  // ---------------- scoreboard ----------------
  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: Euclid by remainder, LCM from plain arithmetic.
  function automatic void ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [2*W-1:0] l, output logic [W-1:0] g);
    int x, y, t;
    x = int'(a);
    y = int'(b);
    if (x == 0 || y == 0) begin
      g = W'(x + y);
      l = '0;
      return;
    end
    while (y != 0) begin
      t = x % y; x = y; y = t;
    end
    g = W'(x);
    l = (2*W)'((int'(a) * int'(b)) / x);
  endfunction

  // ---------------- driver: one full transaction ----------------
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit stub, input int hold);
    int t_acc, t_done, t_rsp, n_start, guard;
    bit got_done, got_rsp, zero;
    logic [W-1:0]   sa, sb, e_gcd;
    logic [2*W-1:0] e_lcm;
    logic           e_terr;

    ref_model(a, b, e_lcm, e_gcd);
    zero   = (a == 0) || (b == 0);
    e_terr = stub && !zero;
    if (e_terr) begin
      e_lcm = '0;
      e_gcd = '0;
    end
    eng_stub  = stub;
    rsp_ready = 1'b0;

    @(negedge clk);
    guard = 0;
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("req_ready_idle", req_ready, 1);

    req_valid = 1'b1; req_a = a; req_b = b;
    @(posedge clk); #1;
    t_acc = cyc;
    req_valid = 1'b0; req_a = W'($urandom); req_b = W'($urandom);
    chk("req_ready_after_accept", req_ready, 0);

    n_start = 0; got_done = 0; got_rsp = 0; t_done = 0; t_rsp = 0; sa = '0; sb = '0;
    for (guard = 0; guard < 1200 && !got_rsp; guard++) begin
      @(negedge clk);
      if (gcd_start) begin
        n_start++; sa = gcd_a; sb = gcd_b;
      end else if (n_start > 0 && !got_done && gcd_done) begin
        got_done = 1; t_done = cyc;
      end
      if (rsp_valid) begin
        got_rsp = 1; t_rsp = cyc;
      end
    end
    chk("rsp_seen", got_rsp, 1);

    if (zero) begin
      chk("bypass_no_start", n_start, 0);
      chk("bypass_latency", t_rsp - t_acc, 0);
    end else begin
      chk("start_pulses", n_start, 1);
      chk("engine_operands", {sa, sb}, {a, b});
      if (stub) begin
        chk("timeout_latency", t_rsp - t_acc, 1 + TO);
      end else begin
        chk("done_seen", got_done, 1);
        chk("latency", t_rsp - t_acc, (t_done - t_acc) + 18);
        chk("div_rem_zero", dbg.div_rem_nz, 0);
      end
    end
    chk("lcm_out", lcm_out, e_lcm);
    chk("gcd_q", gcd_q, e_gcd);
    chk("timeout_err", timeout_err, e_terr);

    // Backpressure: response held, requests refused.
    for (int i = 0; i < hold; i++) begin
      req_valid = (i == hold / 2);
      req_a = 8'hA5; req_b = 8'h5A;
      @(negedge clk);
      chk("bp_hold", {rsp_valid, req_ready, lcm_out, gcd_q, timeout_err},
                     {1'b1, 1'b0, e_lcm, e_gcd, e_terr});
    end
    req_valid = 1'b0;

    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("rsp_valid_drop", rsp_valid, 0);
    chk("req_ready_after_rsp", req_ready, 1);
    chk("operands_kept", {gcd_a, gcd_b}, {a, b});
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int guard, n_rsp;
    logic [W-1:0] ra, rb;

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outputs",
        {req_ready, gcd_start, gcd_a, gcd_b, rsp_valid, lcm_out, gcd_q, timeout_err}, 64'd0);
    rst = 1'b0;
    #1;
    chk("ready_low_before_edge", req_ready, 0);
    @(negedge clk);
    chk("ready_after_reset", req_ready, 1);

    // Basic
    do_op(8'd12, 8'd18, 0, 0);
    // Long engine runs
    do_op(8'd255, 8'd1, 0, 0);
    do_op(8'd255, 8'd254, 0, 0);
    // Zero bypass
    do_op(8'd0, 8'd7, 0, 0);
    do_op(8'd9, 8'd0, 0, 0);
    // Timeout, then recovery with a working engine
    do_op(8'd4, 8'd6, 1, 0);
    do_op(8'd4, 8'd6, 0, 0);
    // Backpressure (engine done is still high from the previous op)
    do_op(8'd7, 8'd21, 0, 10);

    // Reset during DIVIDE
    @(negedge clk);
    req_valid = 1'b1; req_a = 8'd24; req_b = 8'd36;
    @(posedge clk); #1;
    req_valid = 1'b0;
    guard = 0;
    while (dbg.state != ST_DIVIDE && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    chk("reached_divide", guard < 300, 1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midreset_outputs",
        {req_ready, gcd_start, gcd_a, gcd_b, rsp_valid, lcm_out, gcd_q, timeout_err}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n_rsp = 0;
    repeat (40) begin
      @(negedge clk);
      if (rsp_valid) n_rsp++;
    end
    chk("midreset_no_rsp", n_rsp, 0);
    do_op(8'd24, 8'd36, 0, 0);

    // Randomized operands and backpressure
    for (int k = 0; k < 25; k++) begin
      ra = ($urandom_range(0, 7) == 0) ? 8'd0 : W'($urandom_range(1, 255));
      rb = ($urandom_range(0, 7) == 0) ? 8'd0 : W'($urandom_range(1, 255));
      do_op(ra, rb, 0, int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
